regfile_write_arbiter: RTL

Shares the single register-file write channel (wr_ena/wr_addr/wr_data) between two writeback producers: requester 0 (ALU writeback) and requester 1 (load-unit writeback). Each requester feeds a small per-port FIFO over a valid/ready handshake. A round-robin arbiter drains the FIFO heads into a registered output stage that drives the register file write port directly. Writes targeting x00 are accepted and discarded, because x00 is tied to ground.

---
 rtl/regfile_write_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two writeback producers feed per-port FIFOs,
// and a round-robin grant drains the FIFO heads into a registered write port.
module regfile_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        wr_ena,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 37;

    logic [EW-1:0] mem_q  [2][DEPTH];
    logic [EW-1:0] mem_d  [2][DEPTH];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];

    logic          last_grant_q;
    logic          last_grant_d;
    logic          wr_ena_q;
    logic          wr_ena_d;
    logic [4:0]    wr_addr_q;
    logic [4:0]    wr_addr_d;
    logic [31:0]   wr_data_q;
    logic [31:0]   wr_data_d;

    logic [1:0]    valid_s;
    logic [1:0]    full_s;
    logic [1:0]    empty_s;
    logic [1:0]    ready_s;
    logic [1:0]    push_s;
    logic [1:0]    pop_s;
    logic [4:0]    addr_s [2];
    logic [31:0]   data_s [2];
    logic          grant_vld_s;
    logic          grant_idx_s;
    logic [EW-1:0] head_s;

    // Per-port FIFO status and accepted-transfer detection (x00 writes never enqueue)
    always_comb begin
        valid_s   = {req1_valid, req0_valid};
        addr_s[0] = req0_addr;
        addr_s[1] = req1_addr;
        data_s[0] = req0_data;
        data_s[1] = req1_data;
        full_s    = 2'b00;
        empty_s   = 2'b00;
        ready_s   = 2'b00;
        push_s    = 2'b00;
        for (int p = 0; p < 2; p++) begin
            full_s[p]  = (cnt_q[p] == CW'(DEPTH));
            empty_s[p] = (cnt_q[p] == {CW{1'b0}});
            ready_s[p] = !full_s[p] && !rst;
            push_s[p]  = valid_s[p] && ready_s[p] && (addr_s[p] != 5'd0);
        end
    end

    // Round-robin grant over the FIFO heads; on a tie the port that did not win last goes
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 1'b0;
        if (!empty_s[0] && !empty_s[1]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = ~last_grant_q;
        end else if (!empty_s[0]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = 1'b0;
        end else if (!empty_s[1]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_idx_s = 1'b0;
        end
        pop_s        = {grant_vld_s && grant_idx_s, grant_vld_s && !grant_idx_s};
        last_grant_d = grant_vld_s ? grant_idx_s : last_grant_q;
        head_s       = mem_q[grant_idx_s][rptr_q[grant_idx_s]];
    end

    // FIFO next state: storage write, pointer advance (wraps naturally) and occupancy
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[p][i] = mem_q[p][i];
            end
            wptr_d[p] = wptr_q[p];
            rptr_d[p] = rptr_q[p];
            cnt_d[p]  = cnt_q[p];
            if (push_s[p]) begin
                mem_d[p][wptr_q[p]] = {addr_s[p], data_s[p]};
                wptr_d[p]           = wptr_q[p] + PW'(1);
            end else begin
                wptr_d[p] = wptr_q[p];
            end
            if (pop_s[p]) begin
                rptr_d[p] = rptr_q[p] + PW'(1);
            end else begin
                rptr_d[p] = rptr_q[p];
            end
            case ({push_s[p], pop_s[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CW'(1);
                2'b01:   cnt_d[p] = cnt_q[p] - CW'(1);
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    // Output stage: a granted head becomes next cycle's write; address/data hold otherwise
    always_comb begin
        wr_ena_d = grant_vld_s;
        if (grant_vld_s) begin
            wr_addr_d = head_s[36:32];
            wr_data_d = head_s[31:0];
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // Control state registers; reset discards queued entries and rearms port 0 for the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= {PW{1'b0}};
                rptr_q[p] <= {PW{1'b0}};
                cnt_q[p]  <= {CW{1'b0}};
            end
            last_grant_q <= 1'b1;
            wr_ena_q     <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_data_q    <= 32'd0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= wptr_d[p];
                rptr_q[p] <= rptr_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
            last_grant_q <= last_grant_d;
            wr_ena_q     <= wr_ena_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the count, so no reset is needed
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[p][i] <= mem_d[p][i];
            end
        end
    end

    assign req0_ready = ready_s[0];
    assign req1_ready = ready_s[1];
    assign wr_ena     = wr_ena_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign idle       = (cnt_q[0] == {CW{1'b0}}) && (cnt_q[1] == {CW{1'b0}}) && !wr_ena_q;

endmodule
